keypad_entry_ctrl: RTL and testbench

Sequencer for the keypad decoder output (key[3:0], keyIsValid). Turns press-level activity into discrete key events, with auto-repeat while a key is held. Assembles up to NUM_DIGITS decimal digits into a BCD entry buffer. Hex keys A/B/C act as ENTER/BACKSPACE/CLEAR, and committed numbers go to game logic as a one-cycle strobe.

---
 rtl/keypad_entry_ctrl_pkg.sv | 19 +
 rtl/keypad_entry_ctrl_repeat_timer.sv | 25 ++
 rtl/keypad_entry_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/keypad_entry_ctrl_pkg.sv
// Shared types and key decoding helpers for the keypad entry controller.
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} kp_state_t;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_BKSP  = 4'hB;
  localparam logic [3:0] KEY_CLR   = 4'hC;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

  // Only digits and backspace auto-repeat while held.
  function automatic logic can_repeat(input logic [3:0] k);
    return is_digit(k) || (k == KEY_BKSP);
  endfunction

endpackage

// File: rtl/keypad_entry_ctrl_repeat_timer.sv
// Loadable down-counter with a zero flag; parks at zero until reloaded.
module keypad_repeat_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      count_reg <= '0;
    else if (load)
      count_reg <= load_val;
    else if (count_reg != '0)
      count_reg <= count_reg - 1'b1;
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad event sequencer with auto-repeat and a BCD digit entry buffer.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000
) (
  input  logic                            clk,
  input  logic                            resetN,
  input  logic [3:0]                      key,
  input  logic                            keyIsValid,
  output logic [4*NUM_DIGITS-1:0]         entry_bcd,
  output logic [$clog2(NUM_DIGITS+1)-1:0] digit_count,
  output logic [4*NUM_DIGITS-1:0]         value_bcd,
  output logic                            value_strobe,
  output logic                            key_event,
  output logic                            overflow
);

  localparam int DW   = 4 * NUM_DIGITS;
  localparam int CW   = $clog2(NUM_DIGITS + 1);
  localparam int MAXT = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = (MAXT > 1) ? $clog2(MAXT) : 1;

  localparam logic [TW-1:0] DELAY_LOAD = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LOAD  = TW'(REPEAT_RATE - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(NUM_DIGITS);

  logic [3:0]    key_q;
  logic          valid_q;
  kp_state_t     state_reg, state_next;
  logic [3:0]    latch_reg, latch_next;
  logic          fire;
  logic          timer_load;
  logic [TW-1:0] timer_val;
  logic          timer_zero;

  logic [DW-1:0] entry_reg, entry_next;
  logic [CW-1:0] count_reg, count_next;
  logic [DW-1:0] value_reg, value_next;
  logic          strobe_reg, strobe_next;
  logic          event_reg;
  logic          ovf_reg, ovf_next;
  logic [DW-1:0] entry_shl, entry_shr;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      key_q   <= 4'h0;
      valid_q <= 1'b0;
    end else begin
      key_q   <= key;
      valid_q <= keyIsValid;
    end
  end

  keypad_repeat_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .resetN   (resetN),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg <= IDLE;
      latch_reg <= 4'h0;
    end else begin
      state_reg <= state_next;
      latch_reg <= latch_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    latch_next = latch_reg;
    fire       = 1'b0;
    timer_load = 1'b0;
    timer_val  = DELAY_LOAD;
    case (state_reg)
      IDLE: begin
        if (valid_q) begin
          fire       = 1'b1;
          latch_next = key_q;
          timer_load = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD, REPEAT: begin
        if (!valid_q) begin
          state_next = IDLE;
        end else if (key_q != latch_reg) begin
          fire       = 1'b1;
          latch_next = key_q;
          timer_load = 1'b1;
          state_next = HOLD;
        end else if (timer_zero && can_repeat(latch_reg)) begin
          // Non-repeating keys leave the timer parked at zero until release.
          fire       = 1'b1;
          timer_load = 1'b1;
          timer_val  = RATE_LOAD;
          state_next = REPEAT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Per-digit shift networks: left inserts the new key at digit 0, right zero-fills the top.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_shift
    if (gi == 0) begin : g_lo
      assign entry_shl[3:0] = latch_next;
    end else begin : g_mid
      assign entry_shl[4*gi +: 4] = entry_reg[4*(gi-1) +: 4];
    end
    if (gi == NUM_DIGITS - 1) begin : g_hi
      assign entry_shr[4*gi +: 4] = 4'h0;
    end else begin : g_low
      assign entry_shr[4*gi +: 4] = entry_reg[4*(gi+1) +: 4];
    end
  end

  always_comb begin
    entry_next  = entry_reg;
    count_next  = count_reg;
    value_next  = value_reg;
    strobe_next = 1'b0;
    ovf_next    = 1'b0;
    if (fire) begin
      if (is_digit(latch_next)) begin
        if (count_reg != FULL_COUNT) begin
          entry_next = entry_shl;
          count_next = count_reg + 1'b1;
        end else begin
          ovf_next = 1'b1;
        end
      end else begin
        case (latch_next)
          KEY_BKSP: begin
            if (count_reg != '0) begin
              entry_next = entry_shr;
              count_next = count_reg - 1'b1;
            end
          end
          KEY_CLR: begin
            entry_next = '0;
            count_next = '0;
          end
          KEY_ENTER: begin
            if (count_reg != '0) begin
              value_next  = entry_reg;
              strobe_next = 1'b1;
              entry_next  = '0;
              count_next  = '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      entry_reg  <= '0;
      count_reg  <= '0;
      value_reg  <= '0;
      strobe_reg <= 1'b0;
      event_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      entry_reg  <= entry_next;
      count_reg  <= count_next;
      value_reg  <= value_next;
      strobe_reg <= strobe_next;
      event_reg  <= fire;
      ovf_reg    <= ovf_next;
    end
  end

  assign entry_bcd    = entry_reg;
  assign digit_count  = count_reg;
  assign value_bcd    = value_reg;
  assign value_strobe = strobe_reg;
  assign key_event    = event_reg;
  assign overflow     = ovf_reg;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed self-checking bench for keypad_entry_ctrl with short repeat timings.
module tb_keypad_entry_ctrl;
  import keypad_pkg::*;

  localparam int ND = 4;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [3:0]  key = 4'h0;
  logic        keyIsValid = 1'b0;
  logic [15:0] entry_bcd, value_bcd;
  logic [2:0]  digit_count;
  logic        value_strobe, key_event, overflow;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ev_cnt = 0, ovf_cnt = 0, strobe_cnt = 0, both_cnt = 0;
  int ev_cyc[$];
  int start, e0, o0, s0;
  int exp_off[5] = '{2, 22, 27, 32, 37};

  keypad_entry_ctrl #(.NUM_DIGITS(ND), .REPEAT_DELAY(20), .REPEAT_RATE(5)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .key          (key),
    .keyIsValid   (keyIsValid),
    .entry_bcd    (entry_bcd),
    .digit_count  (digit_count),
    .value_bcd    (value_bcd),
    .value_strobe (value_strobe),
    .key_event    (key_event),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (key_event) begin
      ev_cnt++;
      ev_cyc.push_back(cyc);
    end
    if (overflow) ovf_cnt++;
    if (value_strobe) strobe_cnt++;
    if (overflow && value_strobe) both_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tap(input logic [3:0] k);
    key = k;
    keyIsValid = 1'b1;
    step(10);
    keyIsValid = 1'b0;
    step(10);
    $display("tap key=%h entry=%h count=%0d value=%h events=%0d", k, entry_bcd, digit_count, value_bcd, ev_cnt);
  endtask

  initial begin
    step(3);
    check("rst_entry", {16'h0, entry_bcd}, 32'h0);
    check("rst_count", {29'h0, digit_count}, 32'h0);
    check("rst_value", {16'h0, value_bcd}, 32'h0);
    resetN = 1'b1;
    step(2);

    tap(4'h1); check("entry_1", {16'h0, entry_bcd}, 32'h0001);
    tap(4'h2); check("entry_12", {16'h0, entry_bcd}, 32'h0012);
    tap(4'h3); check("entry_123", {16'h0, entry_bcd}, 32'h0123);
    check("count_3", {29'h0, digit_count}, 32'd3);
    tap(KEY_ENTER);
    check("value_123", {16'h0, value_bcd}, 32'h0123);
    check("strobes_1", strobe_cnt, 32'd1);
    check("count_after_enter", {29'h0, digit_count}, 32'd0);
    check("entry_after_enter", {16'h0, entry_bcd}, 32'h0);

    for (int i = 0; i < 4; i++) tap(4'h9);
    check("entry_9999", {16'h0, entry_bcd}, 32'h9999);
    check("count_full", {29'h0, digit_count}, 32'd4);
    check("no_ovf_yet", ovf_cnt, 32'd0);
    tap(4'h9);
    check("ovf_once", ovf_cnt, 32'd1);
    check("entry_kept", {16'h0, entry_bcd}, 32'h9999);

    tap(KEY_CLR);
    check("clear_count", {29'h0, digit_count}, 32'd0);
    ev_cyc.delete();
    o0 = ovf_cnt;
    key = 4'h7;
    keyIsValid = 1'b1;
    start = cyc;
    step(36);
    keyIsValid = 1'b0;
    step(10);
    $display("hold7 events=%0d entry=%h count=%0d", ev_cyc.size(), entry_bcd, digit_count);
    check("rep_events", ev_cyc.size(), 32'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("rep_off%0d", i), (i < ev_cyc.size()) ? ev_cyc[i] - start : -1, exp_off[i]);
    check("rep_entry", {16'h0, entry_bcd}, 32'h7777);
    check("rep_ovf", ovf_cnt - o0, 32'd1);

    tap(KEY_CLR);
    tap(4'h4);
    tap(4'h5); check("entry_45", {16'h0, entry_bcd}, 32'h0045);
    tap(KEY_BKSP); check("bksp_4", {16'h0, entry_bcd}, 32'h0004);
    tap(KEY_BKSP); check("bksp_0", {16'h0, entry_bcd}, 32'h0000);
    e0 = ev_cnt;
    tap(KEY_BKSP);
    check("bksp_empty_entry", {16'h0, entry_bcd}, 32'h0000);
    check("bksp_empty_count", {29'h0, digit_count}, 32'd0);
    check("bksp_empty_event", ev_cnt - e0, 32'd1);

    e0 = ev_cnt;
    key = 4'h3; keyIsValid = 1'b1; step(5);
    key = 4'h6; step(5);
    keyIsValid = 1'b0; step(10);
    $display("switch 3->6 entry=%h events=%0d", entry_bcd, ev_cnt - e0);
    check("switch_events", ev_cnt - e0, 32'd2);
    check("switch_entry", {16'h0, entry_bcd}, 32'h0036);

    tap(KEY_CLR);
    e0 = ev_cnt; s0 = strobe_cnt;
    key = KEY_ENTER; keyIsValid = 1'b1; step(100);
    keyIsValid = 1'b0; step(10);
    $display("hold A events=%0d strobes=%0d", ev_cnt - e0, strobe_cnt - s0);
    check("holdA_events", ev_cnt - e0, 32'd1);
    check("holdA_strobe", strobe_cnt - s0, 32'd0);
    check("holdA_value", {16'h0, value_bcd}, 32'h0123);

    key = 4'h8; keyIsValid = 1'b1; step(10);
    check("pre_rst_entry", {16'h0, entry_bcd}, 32'h0008);
    resetN = 1'b0; step(1);
    check("midrst_entry", {16'h0, entry_bcd}, 32'h0);
    check("midrst_count", {29'h0, digit_count}, 32'd0);
    check("midrst_value", {16'h0, value_bcd}, 32'h0);
    check("midrst_pulses", {29'h0, key_event, overflow, value_strobe}, 32'h0);
    check("midrst_state", {30'h0, dut.state_reg}, {30'h0, IDLE});
    step(4);
    e0 = ev_cnt;
    resetN = 1'b1; step(3);
    $display("post reset entry=%h events=%0d", entry_bcd, ev_cnt - e0);
    check("postrst_event", ev_cnt - e0, 32'd1);
    check("postrst_entry", {16'h0, entry_bcd}, 32'h0008);
    keyIsValid = 1'b0; step(10);
    check("never_both", both_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
